// File: rtl/ravan_pkg.sv
// Shared types for the RAVAN command front end: sequencer states and the
// request record that is queued ahead of the crypto core.
package ravan_pkg;

  localparam int RAVAN_KEY_W  = 512;
  localparam int RAVAN_ADDR_W = 32;
  localparam int RAVAN_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    KEYWAIT = 2'd1,
    BUSY    = 2'd2,
    RESP    = 2'd3
  } state_e;

  typedef struct packed {
    logic                    enc;
    logic                    mem;
    logic [RAVAN_ADDR_W-1:0] addr;
    logic [RAVAN_DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/ravan_req_fifo.sv
// Request queue in front of the sequencer: DEPTH-entry synchronous FIFO with
// the oldest entry always visible at head_o.
module ravan_req_fifo
  import ravan_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  req_t        push_data_i,
  input  logic        pop_i,
  output req_t        head_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  req_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers are log2(DEPTH) bits wide so they wrap without explicit compares.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/ravan_cmd_sequencer.sv
// Front end for the RAVAN crypto core: queues requests, installs the master
// key, holds core inputs for the core latency and returns one result at a time.
module ravan_cmd_sequencer
  import ravan_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int CORE_LAT = 3,
  parameter int KEY_LAT  = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_load,
  input  logic [RAVAN_KEY_W-1:0] key_in,
  output logic                   key_ready,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_enc,
  input  logic                   req_mem,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_data,
  output logic                   core_enc_op_sel,
  output logic                   core_mem_sel,
  output logic [ADDR_W-1:0]      core_address,
  output logic [DATA_W-1:0]      core_data_in,
  output logic [RAVAN_KEY_W-1:0] core_key,
  input  logic [DATA_W-1:0]      core_data_out,
  input  logic                   core_sha_error,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int KCW = $clog2(KEY_LAT + 1);
  localparam int CCW = $clog2(CORE_LAT + 1);

  localparam logic [AW:0]    FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [KCW-1:0] KCNT_INIT = KCW'(KEY_LAT);
  localparam logic [KCW-1:0] KCNT_ONE  = KCW'(1);
  localparam logic [CCW-1:0] CCNT_INIT = CCW'(CORE_LAT);
  localparam logic [CCW-1:0] CCNT_ONE  = CCW'(1);

  state_e                 state_q, state_d;
  logic [KCW-1:0]         kcnt_q, kcnt_d;
  logic [CCW-1:0]         ccnt_q, ccnt_d;
  logic                   key_valid_q, key_valid_d;
  logic                   err_acc_q, err_acc_d;
  logic                   core_enc_q, core_enc_d;
  logic                   core_mem_q, core_mem_d;
  logic [ADDR_W-1:0]      core_addr_q, core_addr_d;
  logic [DATA_W-1:0]      core_data_q, core_data_d;
  logic [RAVAN_KEY_W-1:0] core_key_q, core_key_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]      rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;

  req_t        req_in;
  req_t        fifo_head;
  logic        fifo_push, fifo_pop;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_count;

  assign req_in    = '{enc: req_enc, mem: req_mem, addr: req_addr, data: req_data};
  assign req_ready = (fifo_count != FULL_CNT);
  assign fifo_push = req_valid & ~fifo_full;

  ravan_req_fifo #(
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (req_in),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign key_ready       = (state_q == IDLE);
  assign core_enc_op_sel = core_enc_q;
  assign core_mem_sel    = core_mem_q;
  assign core_address    = core_addr_q;
  assign core_data_in    = core_data_q;
  assign core_key        = core_key_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_err         = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    kcnt_d      = kcnt_q;
    ccnt_d      = ccnt_q;
    key_valid_d = key_valid_q;
    err_acc_d   = err_acc_q;
    core_enc_d  = core_enc_q;
    core_mem_d  = core_mem_q;
    core_addr_d = core_addr_q;
    core_data_d = core_data_q;
    core_key_d  = core_key_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;

    case (state_q)
      IDLE: begin
        // A key reload wins over issue; queued requests then use the new key.
        if (key_load) begin
          core_key_d  = key_in;
          key_valid_d = 1'b0;
          kcnt_d      = KCNT_INIT;
          state_d     = KEYWAIT;
        end else if (key_valid_q && !fifo_empty) begin
          fifo_pop    = 1'b1;
          core_enc_d  = fifo_head.enc;
          core_mem_d  = fifo_head.mem;
          core_addr_d = fifo_head.addr;
          core_data_d = fifo_head.data;
          ccnt_d      = CCNT_INIT;
          err_acc_d   = 1'b0;
          state_d     = BUSY;
        end
      end
      KEYWAIT: begin
        kcnt_d = kcnt_q - KCNT_ONE;
        if (kcnt_q == KCNT_ONE) begin
          key_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      BUSY: begin
        err_acc_d = err_acc_q | core_sha_error;
        ccnt_d    = ccnt_q - CCNT_ONE;
        if (ccnt_q == CCNT_ONE) begin
          rsp_data_d  = core_data_out;
          rsp_err_d   = err_acc_q | core_sha_error;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      kcnt_q      <= '0;
      ccnt_q      <= '0;
      key_valid_q <= 1'b0;
      err_acc_q   <= 1'b0;
      core_enc_q  <= 1'b0;
      core_mem_q  <= 1'b0;
      core_addr_q <= '0;
      core_data_q <= '0;
      core_key_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      kcnt_q      <= kcnt_d;
      ccnt_q      <= ccnt_d;
      key_valid_q <= key_valid_d;
      err_acc_q   <= err_acc_d;
      core_enc_q  <= core_enc_d;
      core_mem_q  <= core_mem_d;
      core_addr_q <= core_addr_d;
      core_data_q <= core_data_d;
      core_key_q  <= core_key_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: doc/ravan_cmd_sequencer.md
Name: ravan_cmd_sequencer

Overview:
- Front-end stage directly upstream of the RAVAN crypto top level.
- Accepts encrypt/decrypt requests over a valid/ready interface and buffers them in a small FIFO.
- Installs the 512-bit master key and waits out the key-hash pipeline before issuing anything.
- Drives the core's op/mem-select, address and data lines stable for the core's fixed latency, then returns each result and the hash error flag over a valid/ready response channel.

Parameters:
- DEPTH, 4: request FIFO entries (power of two, ≥2).
- CORE_LAT, 3: cycles from core input change to valid core data_out.
- KEY_LAT, 4: cycles from key install to hashed key usable by the core.
- ADDR_W, 32: address width.
- DATA_W, 64: data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- key_load  in  1  install key_in (honoured only when key_ready=1).
- key_in  in  512  master key.
- key_ready  out  1  high only in IDLE.
- req_valid  in  1  request present.
- req_ready  out  1  = (fifo_count != DEPTH); depends on registered count only.
- req_enc  in  1  1=encrypt, 0=decrypt.
- req_mem  in  1  mem_sel value for the core.
- req_addr  in  ADDR_W  request address.
- req_data  in  DATA_W  plaintext or ciphertext.
- core_enc_op_sel  out  1  to core enc_op_sel.
- core_mem_sel  out  1  to core mem_sel.
- core_address  out  ADDR_W  to core address.
- core_data_in  out  DATA_W  to core data_in.
- core_key  out  512  to core key; registered.
- core_data_out  in  DATA_W  from core data_out.
- core_sha_error  in  1  from core sha_error.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  DATA_W  captured core result.
- rsp_err  out  1  sha_error seen during this command.

Behaviour:
- Reset: all outputs 0 except key_ready=1 and req_ready=1; FIFO emptied; key_valid=0; state=IDLE. Reset mid-operation discards queued and in-flight commands with no response.
- Push: req_valid & req_ready at an edge. Pop: IDLE→BUSY transition only. Push and pop in the same cycle are legal; count is unchanged.
- When full, req_ready=0 even if a pop occurs that cycle.
- States:
  - IDLE:
    - key_load=1 → latch core_key=key_in, clear key_valid, load kcnt=KEY_LAT, go KEYWAIT. key_load has priority over issue.
    - Else if key_valid & FIFO non-empty → pop head, register core_* from the entry, load ccnt=CORE_LAT, clear err_acc, go BUSY.
    - Else hold.
  - KEYWAIT:
    - Decrement kcnt; at kcnt==1 set key_valid and go IDLE.
    - Requests may still be pushed.
    - key_load here is ignored.
  - BUSY:
    - core_* held stable.
    - err_acc |= core_sha_error every cycle.
    - Decrement ccnt; at ccnt==1 capture rsp_data=core_data_out and rsp_err=err_acc|core_sha_error, set rsp_valid, go RESP.
  - RESP:
    - rsp_valid held; rsp_data/rsp_err stable until rsp_valid & rsp_ready.
    - At the handshake, clear rsp_valid and go IDLE.
    - No pipelining across commands.
- Latency: request pushed at edge t into an empty FIFO, key valid, IDLE → core inputs change at edge t+1 → rsp_valid high after edge t+1+CORE_LAT. With defaults, 4 cycles after acceptance.
- Issue is in-order; one command in flight at most.
- No requests are issued while key_valid=0. Queued requests survive a key reload and are issued with the new key.
- core_* outputs retain the last command's values in IDLE; they are not zeroed.
- Widths are fixed; no arithmetic beyond counters.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.

Decomposition:
- Package ravan_pkg holds:
  - state enum {IDLE, KEYWAIT, BUSY, RESP};
  - packed request struct {enc, mem, addr, data} (1+1+ADDR_W+DATA_W bits);
  - key width constant RAVAN_KEY_W=512.
- One sub-module, ravan_req_fifo:
  - synchronous FIFO of request structs, DEPTH entries;
  - push/pop/full/empty/count outputs, first-word visible at head.
- Sequencer FSM, counters and response registers stay in ravan_cmd_sequencer.

Test Plan:
- Key install: key_load with key_in=512'hA5..A5 in IDLE → core_key=A5..A5 next cycle, key_ready=0 for exactly KEY_LAT=4 cycles, then 1.
- Single encrypt: push {enc=1, mem=1, addr=32'h10, data=64'h0123456789ABCDEF}; core model returns data+1 after 3 cycles → rsp_valid 4 cycles after acceptance, rsp_data=64'h0123456789ABCDF0, rsp_err=0.
- Backpressure/full: hold rsp_ready=0 and push 6 requests →
  - first issued;
  - 4 queued, req_ready=0 while count=4;
  - responses return in push order once rsp_ready=1;
  - no entry lost or duplicated.
- No key: push 2 requests after reset without key_load → no core_* change, rsp_valid stays 0. After key_load plus 4 cycles, both are issued in order.
- SHA error: core_sha_error pulses 1 cycle mid-BUSY → rsp_err=1 for that command only; next command rsp_err=0.
- Reset mid-op: assert rst during BUSY with 3 queued → next cycle rsp_valid=0, req_ready=1, key_ready=1. No further issue until a new key_load completes.
